pc_next_reg: RTL
================

Name: pc_next_reg

Overview:
- Parametrised next-PC selector and program-counter register; successor to the fixed 8-bit 2:1 next-PC mux.
- Selects between sequential increment and up to NUM_SRC-1 external redirect targets (branch, jump, vector, ...).
- Holds the PC under stall and buffers one redirect that arrives during a stall.
- Sits between the control unit (redirect requests) and instruction memory (pc).

Parameters:
WIDTH, 8, PC width in bits
NUM_SRC, 4, number of source lanes (lane 0 = internal increment, lanes 1..NUM_SRC-1 external); min 2
SEL_W, 2, width of redir_sel; must be >= clog2(NUM_SRC)
RESET_PC, 0, PC value loaded on reset
INC, 1, increment step, modulo 2^WIDTH

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
stall  input  1  hold PC this cycle
redir_valid  input  1  redirect request valid
redir_ready  output  1  redirect can be accepted; equals NOT pend_valid
redir_sel  input  SEL_W  target lane index
src_bus  input  NUM_SRC*WIDTH  lane k at bits [k*WIDTH +: WIDTH]; lane 0 ignored
pc  output  WIDTH  registered current PC
pc_plus  output  WIDTH  combinational pc+INC, modulo 2^WIDTH
redirected  output  1  registered pulse, high in the cycle pc first shows a redirect target
pc_wrap  output  1  registered pulse, high in the cycle pc shows a wrapped increment
sel_err  output  1  registered pulse, an accepted redirect had redir_sel == 0 or >= NUM_SRC

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values:
  - pc = RESET_PC; pc_plus = RESET_PC+INC.
  - Pending buffer cleared; redir_ready = 1.
  - redirected = 0; pc_wrap = 0; sel_err = 0.
- Priority of rst: rst overrides every other input in that cycle. A pending redirect is discarded.
- Internal state: pend_valid (1 bit) and pend_addr (WIDTH bits).
- Acceptance rule: accept = redir_valid AND redir_ready. redir_valid with redir_ready=0 is ignored; the requester must hold it.
- Valid target rule: an accepted request is a valid target only when 1 <= redir_sel < NUM_SRC.
  - Otherwise it is dropped: sel_err pulses next cycle and pc behaves as if no request.
- Update rules, per cycle when rst=0:
  - stall=0, pend_valid=1: pc <= pend_addr; pend_valid <= 0; redirected <= 1. redir_ready is 0 this cycle, so no new request is taken.
  - stall=0, pend_valid=0, accepted valid target: pc <= src_bus lane redir_sel; redirected <= 1. Latency is 1 cycle from request to pc.
  - stall=0, no redirect: pc <= pc+INC, truncated to WIDTH. pc_wrap <= 1 iff the sum carries out of WIDTH.
  - stall=1: pc holds. An accepted valid target captures its lane into pend_addr and sets pend_valid <= 1. redirected stays 0.
- Pulse outputs: redirected, pc_wrap and sel_err are 0 in every cycle where their condition does not hold.
- Stall hold: a pending redirect survives any number of stall cycles and is applied on the first cycle with stall=0.
- Lane sampling: target data is sampled only in the accept cycle. Later changes to src_bus do not affect pend_addr.
- No combinational path from redir_valid to redir_ready.

Test Plan:
- Defaults (WIDTH=8, NUM_SRC=4, RESET_PC=0, INC=1); rst 1 cycle, then idle 3 cycles -> pc 0x00, 0x01, 0x02, 0x03; redir_ready=1; all pulses 0.
- Free-run from pc=0xFE -> pc 0xFF then 0x00; pc_wrap=1 only in the 0x00 cycle; pc_plus=0x01 there.
- pc=0x10, stall=0, redir_valid=1, redir_sel=2, lane2=0x80 -> next cycle pc=0x80 and redirected=1; following cycle pc=0x81 and redirected=0.
- Redirect during stall:
  - pc=0x05, stall=1, redir_sel=1, lane1=0x40 accepted.
  - Next cycle: redir_ready=0, pc=0x05. A request with redir_sel=3, lane3=0x99 is held 2 cycles and not taken.
  - Drop stall -> pc=0x40, redirected=1. Next cycle redir_ready=1; the held 0x99 request is then accepted -> pc=0x99.
- redir_sel=0, and a NUM_SRC=3 build with redir_sel=3 -> sel_err=1 for one cycle; pc increments normally; redirected=0.
- Capture pending at pc=0x20 under stall, then rst=1 with stall=1 -> pc=RESET_PC, redir_ready=1. After stall release pc=RESET_PC+1 (pending discarded).

Source files
------------

// File: rtl/pc_next_reg.sv
// Program-counter register with a next-PC selector: sequential increment or one of
// several redirect lanes, with a one-deep buffer for a redirect that arrives while stalled.
module pc_next_reg #(
    parameter int WIDTH    = 8,
    parameter int NUM_SRC  = 4,
    parameter int SEL_W    = 2,
    parameter int RESET_PC = 0,
    parameter int INC      = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall,
    input  logic                     redir_valid,
    output logic                     redir_ready,
    input  logic [SEL_W-1:0]         redir_sel,
    input  logic [NUM_SRC*WIDTH-1:0] src_bus,
    output logic [WIDTH-1:0]         pc,
    output logic [WIDTH-1:0]         pc_plus,
    output logic                     redirected,
    output logic                     pc_wrap,
    output logic                     sel_err
);

    localparam logic [WIDTH-1:0] RESET_PC_W  = WIDTH'(RESET_PC);
    localparam logic [WIDTH-1:0] INC_W       = WIDTH'(INC);
    localparam logic [SEL_W:0]   NUM_SRC_W   = (SEL_W+1)'(NUM_SRC);

    logic             pend_valid;
    logic [WIDTH-1:0] pend_addr;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] target;
    logic             accept;
    logic             sel_ok;
    logic             unused_lane0;

    // Handshake: a request transfers only in a cycle where redir_valid and redir_ready
    // are both high; redir_ready depends on buffer state alone, never on redir_valid.
    assign redir_ready  = ~pend_valid;
    assign accept       = redir_valid & redir_ready;
    assign sel_ok       = (redir_sel != '0) && ({1'b0, redir_sel} < NUM_SRC_W);
    assign sum          = {1'b0, pc} + {1'b0, INC_W};
    assign pc_plus      = sum[WIDTH-1:0];
    assign unused_lane0 = ^src_bus[WIDTH-1:0];

    always_comb begin
        target = '0;
        for (int k = 1; k < NUM_SRC; k++) begin
            if (redir_sel == SEL_W'(k)) begin
                target = src_bus[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_PC_W;
            pend_valid <= 1'b0;
            pend_addr  <= '0;
            redirected <= 1'b0;
            pc_wrap    <= 1'b0;
            sel_err    <= 1'b0;
        end else begin
            redirected <= 1'b0;
            pc_wrap    <= 1'b0;
            sel_err    <= accept & ~sel_ok;
            if (!stall) begin
                if (pend_valid) begin
                    pc         <= pend_addr;
                    pend_valid <= 1'b0;
                    redirected <= 1'b1;
                end else if (accept && sel_ok) begin
                    pc         <= target;
                    redirected <= 1'b1;
                end else begin
                    pc      <= sum[WIDTH-1:0];
                    pc_wrap <= sum[WIDTH];
                end
            end else if (accept && sel_ok) begin
                // Lane is sampled now; later src_bus changes must not reach pend_addr.
                pend_addr  <= target;
                pend_valid <= 1'b1;
            end
        end
    end

endmodule
